mcpu_ctrl: RTL and testbench
============================

MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-002 The block SHALL have parameter TMO_W, default 4, meaning the width of the memory-wait timeout counter; the timeout limit is 2^TMO_W-1 cycles.
REQ-003 The block SHALL have parameter EN_IMM, default 1, meaning ADDI, ANDI, ORI and SLTI are decoded; when 0 these opcodes are illegal.
REQ-004 The block SHALL have the following ports, one per line:
  clk  in  1  clock, rising edge
  rst  in  1  reset, synchronous and active-high
  ir_data  in  32  current instruction register contents
  zero  in  1  ALU zero flag
  mem_ready  in  1  memory completes the current access this cycle
  mem_req  out  1  memory access request
  write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst, write_c, alu_srcA, write_a, write_b, write_reg  out  1 each  datapath strobes and selects
  pcsource  out  2  next-PC select: 00 ALU, 01 C register, 10 jump target, 11 trap vector
  alu_srcB  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate
  alu_ctrl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
  state  out  4  current FSM state
  insn_stage  out  3  000 IF, 001 ID, 010 EX, 011 MEM, 100 WB
  retired  out  CNT_W  count of completed instructions
  illegal  out  1  sticky illegal-opcode flag
  bus_err  out  1  sticky memory-timeout flag

Function
REQ-005 All control outputs SHALL be a combinational decode of the registered state, plus ir_data, zero and mem_ready where stated; any strobe not listed for a state SHALL be 0.
REQ-006 The state encodings SHALL be: IF=0, ID=1, EX_R=2, EX_I=3, EX_ADR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_LD=9, BR=10, JMP=11, TRAP=15.
REQ-007 In IF the block SHALL assert mem_req, drive iord=0, alu_srcA=0, alu_srcB=01 and ADD. write_ir and write_pc with pcsource=00 SHALL be asserted only in the cycle where mem_ready=1, which is also the cycle the FSM moves to ID.
REQ-008 In ID the block SHALL assert write_a and write_b, compute the branch target (alu_srcA=0, alu_srcB=11, ADD) with write_c=1, and branch on ir_data[31:26]:
  - 000000 goes to EX_R.
  - 001000, 001100, 001101 and 001010 go to EX_I when EN_IMM=1.
  - 100011 and 101011 go to EX_ADR.
  - 000100 and 000101 go to BR.
  - 000010 goes to JMP.
  - Any other opcode goes to TRAP.
REQ-009 EX_R SHALL drive alu_srcA=1, alu_srcB=00 and write_c=1. alu_ctrl SHALL be selected from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct goes to TRAP instead of WB_R.
REQ-010 EX_I SHALL drive alu_srcA=1, alu_srcB=10 and write_c=1, with alu_ctrl ADD, AND, OR or SLT for opcodes 001000, 001100, 001101 and 001010 respectively, then go to WB_I.
REQ-011 EX_ADR SHALL drive alu_srcA=1, alu_srcB=10, ADD and write_c=1, then go to MEM_RD for a load or MEM_WR for a store.
REQ-012 MEM_RD and MEM_WR SHALL assert mem_req and iord=1; MEM_WR SHALL also assert write_mem. MEM_RD SHALL assert write_dr only when mem_ready=1. On mem_ready=1, MEM_RD goes to WB_LD and MEM_WR goes to IF.
REQ-013 WB_R SHALL assert write_reg with regdst=1 and memtoreg=0. WB_I SHALL assert write_reg with regdst=0 and memtoreg=0. WB_LD SHALL assert write_reg with regdst=0 and memtoreg=1. All three go to IF.
REQ-014 BR SHALL drive alu_srcA=1, alu_srcB=00, SUB and pcsource=01. write_pc SHALL equal zero for opcode 000100 and ~zero for opcode 000101. BR goes to IF.
REQ-015 JMP SHALL assert write_pc with pcsource=10, then go to IF.
REQ-016 TRAP SHALL assert write_pc with pcsource=11, then go to IF.
REQ-017 Entering TRAP from decode SHALL set illegal. Entering TRAP from a memory-wait timeout SHALL set bus_err.
REQ-018 A timeout counter SHALL clear on every state change and increment each cycle that mem_req=1 and mem_ready=0. When it reaches 2^TMO_W-1 with mem_ready still 0, the next state SHALL be TRAP.
REQ-019 mem_ready=1 on the same cycle as the timeout limit SHALL complete the access normally, with no trap.
REQ-020 retired SHALL increment by 1 on each transition into IF from WB_R, WB_I, WB_LD, MEM_WR, BR or JMP, and SHALL wrap modulo 2^CNT_W. A transition from TRAP SHALL NOT count.
REQ-021 insn_stage SHALL follow the state: IF→IF, ID→ID, EX_*/BR/JMP/TRAP→EX, MEM_*→MEM, WB_*→WB.

Reset
REQ-022 When rst=1 at a rising clk edge, the block SHALL set state=IF, clear retired, illegal, bus_err and the timeout counter, regardless of the current state, including mid memory wait.
REQ-023 Because outputs are decoded from state, after reset mem_req=1 and iord=0, and all write strobes SHALL be 0 until mem_ready=1.

Verification
REQ-024 ADD (funct 100000) with mem_ready tied to 1 -> states IF,ID,EX_R,WB_R,IF over 4 cycles; write_reg=1 with regdst=1 in WB_R; retired 0→1.
REQ-025 LW with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles; write_dr pulses once; WB_LD has memtoreg=1; retired increments once.
REQ-026 BNE with zero=0, then BEQ with zero=0 -> BNE has write_pc=1 in BR with pcsource=01; BEQ has write_pc=0; both retire.
REQ-027 Opcode 111111 -> ID→TRAP→IF; write_pc=1 with pcsource=11; illegal=1; retired unchanged.
REQ-028 TMO_W=2 with mem_ready held 0 in IF -> TRAP after 3 wait cycles; bus_err=1. A repeat run with mem_ready=1 on the 3rd cycle -> normal ID, no trap.
REQ-029 rst=1 asserted during MEM_WR wait with retired=5 -> next cycle state=IF, retired=0, write_mem=0.

Source files
------------

// File: rtl/mcpu_ctrl_if.sv
// Control bundle between the multicycle CPU controller (master) and its datapath (slave).
interface mcpu_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0]      ir_data;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             write_pc, iord, write_mem, write_dr, write_ir, memtoreg;
  logic             regdst, write_c, alu_srcA, write_a, write_b, write_reg;
  logic [1:0]       pcsource;
  logic [1:0]       alu_srcB;
  logic [2:0]       alu_ctrl;
  logic [3:0]       state;
  logic [2:0]       insn_stage;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic             bus_err;

  modport master (
    input  ir_data, zero, mem_ready,
    output mem_req, write_pc, iord, write_mem, write_dr, write_ir, memtoreg,
           regdst, write_c, alu_srcA, write_a, write_b, write_reg,
           pcsource, alu_srcB, alu_ctrl, state, insn_stage, retired, illegal, bus_err
  );
  modport slave (
    output ir_data, zero, mem_ready,
    input  mem_req, write_pc, iord, write_mem, write_dr, write_ir, memtoreg,
           regdst, write_c, alu_srcA, write_a, write_b, write_reg,
           pcsource, alu_srcB, alu_ctrl, state, insn_stage, retired, illegal, bus_err
  );
endinterface

// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS-subset control FSM: strobes are decoded from the registered state,
// with a memory-wait timeout that traps, and a retired-instruction counter.
module mcpu_ctrl #(
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 4,
  parameter bit EN_IMM = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mcpu_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_IF     = 4'd0,  S_ID     = 4'd1,  S_EX_R   = 4'd2,  S_EX_I   = 4'd3,
    S_EX_ADR = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,  S_WB_LD  = 4'd9,  S_BR     = 4'd10, S_JMP    = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI   = 6'b001101, OP_SLTI = 6'b001010, OP_LW   = 6'b100011,
                         OP_SW    = 6'b101011, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101,
                         OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_OR  = 6'b100101, FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_SLT = 3'b100;
  // Last count value before the limit; a still-stalled access here traps next.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, bus_err_q;
  logic [5:0]       op, fn;
  logic             imm_op, fn_ok, mem_phase, tmo_hit, retire, dec_trap;
  logic [2:0]       fn_alu, imm_alu;

  assign op = bus.ir_data[31:26];
  assign fn = bus.ir_data[5:0];

  always_comb begin
    fn_ok  = 1'b1;
    fn_alu = ALU_ADD;
    case (fn)
      FN_ADD:  fn_alu = ALU_ADD;
      FN_SUB:  fn_alu = ALU_SUB;
      FN_AND:  fn_alu = ALU_AND;
      FN_OR:   fn_alu = ALU_OR;
      FN_SLT:  fn_alu = ALU_SLT;
      default: fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    imm_op  = EN_IMM;
    imm_alu = ALU_ADD;
    case (op)
      OP_ADDI: imm_alu = ALU_ADD;
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_op  = 1'b0;
    endcase
  end

  assign mem_phase = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign tmo_hit   = mem_phase && !bus.mem_ready && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:     if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_RTYPE:      state_d = S_EX_R;
          OP_LW, OP_SW:  state_d = S_EX_ADR;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:          state_d = S_JMP;
          default:       state_d = imm_op ? S_EX_I : S_TRAP;
        endcase
      end
      S_EX_R:   state_d = fn_ok ? S_WB_R : S_TRAP;
      S_EX_I:   state_d = S_WB_I;
      S_EX_ADR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_LD;
      S_MEM_WR: if (bus.mem_ready) state_d = S_IF;
      default:  state_d = S_IF;
    endcase
    if (tmo_hit) state_d = S_TRAP;
  end

  // TRAP exits to IF without counting; a timed-out store never reaches IF here.
  assign retire = (state_d == S_IF) &&
                  ((state_q == S_WB_R) || (state_q == S_WB_I) || (state_q == S_WB_LD) ||
                   (state_q == S_MEM_WR) || (state_q == S_BR) || (state_q == S_JMP));
  assign dec_trap = (state_d == S_TRAP) && !tmo_hit &&
                    ((state_q == S_ID) || (state_q == S_EX_R));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      tmo_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)               tmo_q <= '0;
      else if (mem_phase && !bus.mem_ready) tmo_q <= tmo_q + 1'b1;
      if (retire)   retired_q <= retired_q + 1'b1;
      if (dec_trap) illegal_q <= 1'b1;
      if (tmo_hit)  bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.write_pc  = 1'b0;
    bus.iord      = 1'b0;
    bus.write_mem = 1'b0;
    bus.write_dr  = 1'b0;
    bus.write_ir  = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.regdst    = 1'b0;
    bus.write_c   = 1'b0;
    bus.alu_srcA  = 1'b0;
    bus.write_a   = 1'b0;
    bus.write_b   = 1'b0;
    bus.write_reg = 1'b0;
    bus.pcsource  = 2'b00;
    bus.alu_srcB  = 2'b00;
    bus.alu_ctrl  = ALU_ADD;
    case (state_q)
      S_IF: begin
        bus.mem_req  = 1'b1;
        bus.alu_srcB = 2'b01;
        bus.write_ir = bus.mem_ready;
        bus.write_pc = bus.mem_ready;
      end
      S_ID: begin
        bus.write_a  = 1'b1;
        bus.write_b  = 1'b1;
        bus.write_c  = 1'b1;
        bus.alu_srcB = 2'b11;
      end
      S_EX_R: begin
        bus.alu_srcA = 1'b1;
        bus.write_c  = 1'b1;
        bus.alu_ctrl = fn_alu;
      end
      S_EX_I: begin
        bus.alu_srcA = 1'b1;
        bus.alu_srcB = 2'b10;
        bus.write_c  = 1'b1;
        bus.alu_ctrl = imm_alu;
      end
      S_EX_ADR: begin
        bus.alu_srcA = 1'b1;
        bus.alu_srcB = 2'b10;
        bus.write_c  = 1'b1;
      end
      S_MEM_RD: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.write_dr = bus.mem_ready;
      end
      S_MEM_WR: begin
        bus.mem_req   = 1'b1;
        bus.iord      = 1'b1;
        bus.write_mem = 1'b1;
      end
      S_WB_R: begin
        bus.write_reg = 1'b1;
        bus.regdst    = 1'b1;
      end
      S_WB_I:  bus.write_reg = 1'b1;
      S_WB_LD: begin
        bus.write_reg = 1'b1;
        bus.memtoreg  = 1'b1;
      end
      S_BR: begin
        bus.alu_srcA = 1'b1;
        bus.alu_ctrl = ALU_SUB;
        bus.pcsource = 2'b01;
        bus.write_pc = (op == OP_BEQ) ? bus.zero : ((op == OP_BNE) ? ~bus.zero : 1'b0);
      end
      S_JMP: begin
        bus.write_pc = 1'b1;
        bus.pcsource = 2'b10;
      end
      S_TRAP: begin
        bus.write_pc = 1'b1;
        bus.pcsource = 2'b11;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IF:               bus.insn_stage = 3'b000;
      S_ID:               bus.insn_stage = 3'b001;
      S_MEM_RD, S_MEM_WR: bus.insn_stage = 3'b011;
      S_WB_R, S_WB_I, S_WB_LD: bus.insn_stage = 3'b100;
      default:            bus.insn_stage = 3'b010;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: instruction vector table, hand-built stall/reset sequences and a
// randomized program checked against an instruction-level reference model.
module tb_mcpu_ctrl;
  localparam int TMO_LIM_A = 15;
  localparam int B_MREQ = 19, B_WPC = 18, B_IORD = 17, B_WMEM = 16, B_WDR = 15, B_WIR = 14,
                 B_M2R  = 13, B_RDST = 12, B_WC = 11, B_SA = 10, B_WA = 9, B_WB = 8, B_WREG = 7;

  typedef int iq_t[$];
  // st holds the expected state per cycle, one nibble per cycle starting at the low nibble.
  typedef struct {
    logic [31:0]     ir;
    logic            z;
    int              n;
    logic [7:0][3:0] st;
    int              ret;
    logic            ill;
  } vec_t;

  logic clk, rst;
  mcpu_ctrl_if #(.CNT_W(16)) a ();
  mcpu_ctrl_if #(.CNT_W(16)) b ();

  mcpu_ctrl #(.CNT_W(16), .TMO_W(4), .EN_IMM(1'b1)) u_dut   (.clk(clk), .rst(rst), .bus(a.master));
  mcpu_ctrl #(.CNT_W(16), .TMO_W(2), .EN_IMM(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(b.master));

  logic [19:0] ctl_a;
  assign ctl_a = {a.mem_req, a.write_pc, a.iord, a.write_mem, a.write_dr, a.write_ir, a.memtoreg,
                  a.regdst, a.write_c, a.alu_srcA, a.write_a, a.write_b, a.write_reg,
                  a.pcsource, a.alu_srcB, a.alu_ctrl};

  int checks = 0, failures = 0;
  vec_t tv[$];
  int n, low, rd, pulses, m2r, cur, wait_n, ret_m;
  logic ill_m, bus_m, stall, mr, z;
  logic [31:0] ir;
  int q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic drv_a(input logic [31:0] i, input logic zz, input logic m);
    a.ir_data = i; a.zero = zz; a.mem_ready = m;
  endtask

  task automatic drv_b(input logic [31:0] i, input logic zz, input logic m);
    b.ir_data = i; b.zero = zz; b.mem_ready = m;
  endtask

  function automatic logic [2:0] fn_alu(input logic [5:0] f);
    case (f)
      6'h20: return 3'd0;
      6'h22: return 3'd1;
      6'h24: return 3'd2;
      6'h25: return 3'd3;
      6'h2A: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      6'h0C: return 3'd2;
      6'h0D: return 3'd3;
      6'h0A: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Control word each state must present, from the state-by-state strobe rules.
  function automatic logic [19:0] exp_ctl(input int st, input logic [31:0] i, input logic zz, input logic m);
    logic [19:0] v;
    logic [5:0]  o;
    o = i[31:26];
    v = '0;
    case (st)
      0:  begin v[B_MREQ] = 1'b1; v[4:3] = 2'b01; v[B_WPC] = m; v[B_WIR] = m; end
      1:  begin v[B_WA] = 1'b1; v[B_WB] = 1'b1; v[B_WC] = 1'b1; v[4:3] = 2'b11; end
      2:  begin v[B_SA] = 1'b1; v[B_WC] = 1'b1; v[2:0] = fn_alu(i[5:0]); end
      3:  begin v[B_SA] = 1'b1; v[B_WC] = 1'b1; v[4:3] = 2'b10; v[2:0] = imm_alu(o); end
      4:  begin v[B_SA] = 1'b1; v[B_WC] = 1'b1; v[4:3] = 2'b10; end
      5:  begin v[B_MREQ] = 1'b1; v[B_IORD] = 1'b1; v[B_WDR] = m; end
      6:  begin v[B_MREQ] = 1'b1; v[B_IORD] = 1'b1; v[B_WMEM] = 1'b1; end
      7:  begin v[B_WREG] = 1'b1; v[B_RDST] = 1'b1; end
      8:  v[B_WREG] = 1'b1;
      9:  begin v[B_WREG] = 1'b1; v[B_M2R] = 1'b1; end
      10: begin
        v[B_SA] = 1'b1; v[2:0] = 3'd1; v[6:5] = 2'b01;
        v[B_WPC] = (o == 6'h04) ? zz : ((o == 6'h05) ? ~zz : 1'b0);
      end
      11: begin v[B_WPC] = 1'b1; v[6:5] = 2'b10; end
      15: begin v[B_WPC] = 1'b1; v[6:5] = 2'b11; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int stage_of(input int st);
    case (st)
      0: return 0;
      1: return 1;
      5, 6: return 3;
      7, 8, 9: return 4;
      default: return 2;
    endcase
  endfunction

  // States an instruction visits after its fetch completes (EN_IMM=1 decoder).
  function automatic iq_t path_of(input logic [31:0] i);
    iq_t p;
    logic [5:0] f;
    f = i[5:0];
    case (i[31:26])
      6'h00: begin
        if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) p = '{1, 2, 7};
        else p = '{1, 2, 15};
      end
      6'h08, 6'h0C, 6'h0D, 6'h0A: p = '{1, 3, 8};
      6'h23: p = '{1, 4, 5, 9};
      6'h2B: p = '{1, 4, 6};
      6'h04, 6'h05: p = '{1, 10};
      6'h02: p = '{1, 11};
      default: p = '{1, 15};
    endcase
    return p;
  endfunction

  function automatic logic [31:0] gen_insn();
    logic [5:0] ops [13];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    logic [31:0] w;
    int k;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    w = $urandom;
    k = $urandom_range(0, 14);
    o = (k < 13) ? ops[k] : 6'($urandom_range(0, 63));
    f = ($urandom_range(0, 5) == 0) ? w[5:0] : fns[$urandom_range(0, 4)];
    return {o, w[25:6], f};
  endfunction

  task automatic chk_ctl_a(input string nm, input int st, input logic [31:0] i, input logic zz, input logic m);
    chk({nm, "_state"}, 32'(a.state), st);
    chk({nm, "_ctl"}, 32'(ctl_a), 32'(exp_ctl(st, i, zz, m)));
    chk({nm, "_stage"}, 32'(a.insn_stage), stage_of(st));
  endtask

  initial begin
    rst = 1'b1;
    drv_a('0, 1'b0, 1'b0);
    drv_b('0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #3;
    chk_ctl_a("rst", 0, '0, 1'b0, 1'b0);
    chk("rst_retired", 32'(a.retired), 0);
    chk("rst_illegal", 32'(a.illegal), 0);
    chk("rst_bus_err", 32'(a.bus_err), 0);

    tv.push_back('{32'h00000020, 1'b0, 4, 32'h00007210, 1, 1'b0});  // ADD
    tv.push_back('{32'h00000022, 1'b0, 4, 32'h00007210, 1, 1'b0});  // SUB
    tv.push_back('{32'h00000024, 1'b0, 4, 32'h00007210, 1, 1'b0});  // AND
    tv.push_back('{32'h0000002A, 1'b0, 4, 32'h00007210, 1, 1'b0});  // SLT
    tv.push_back('{32'h0000003F, 1'b0, 4, 32'h0000F210, 0, 1'b1});  // bad funct
    tv.push_back('{32'h20000000, 1'b0, 4, 32'h00008310, 1, 1'b0});  // ADDI
    tv.push_back('{32'h34000000, 1'b0, 4, 32'h00008310, 1, 1'b0});  // ORI
    tv.push_back('{32'h28000000, 1'b0, 4, 32'h00008310, 1, 1'b0});  // SLTI
    tv.push_back('{32'h8C000000, 1'b0, 5, 32'h00095410, 1, 1'b0});  // LW
    tv.push_back('{32'hAC000000, 1'b0, 4, 32'h00006410, 1, 1'b0});  // SW
    tv.push_back('{32'h14000000, 1'b0, 3, 32'h00000A10, 1, 1'b0});  // BNE z=0 taken
    tv.push_back('{32'h10000000, 1'b0, 3, 32'h00000A10, 1, 1'b0});  // BEQ z=0 not taken
    tv.push_back('{32'h10000000, 1'b1, 3, 32'h00000A10, 1, 1'b0});  // BEQ z=1 taken
    tv.push_back('{32'h08000000, 1'b0, 3, 32'h00000B10, 1, 1'b0});  // J
    tv.push_back('{32'hFC000000, 1'b0, 3, 32'h00000F10, 0, 1'b1});  // opcode 111111

    for (int i = 0; i < tv.size(); i++) begin
      do_reset();
      for (int k = 0; k < tv[i].n; k++) begin
        drv_a(tv[i].ir, tv[i].z, 1'b1);
        #3;
        chk_ctl_a($sformatf("tv%0d_c%0d", i, k), int'(tv[i].st[k]), tv[i].ir, tv[i].z, 1'b1);
        tick();
      end
      #3;
      chk($sformatf("tv%0d_end_state", i), 32'(a.state), 0);
      chk($sformatf("tv%0d_retired", i), 32'(a.retired), tv[i].ret);
      chk($sformatf("tv%0d_illegal", i), 32'(a.illegal), 32'(tv[i].ill));
      chk($sformatf("tv%0d_bus_err", i), 32'(a.bus_err), 0);
    end

    // LW with three stalled cycles in MEM_RD
    do_reset();
    low = 0; rd = 0; pulses = 0; m2r = 0;
    for (int j = 0; j < 8; j++) begin
      mr = 1'b1;
      if (a.state == 4'd5 && low < 3) begin mr = 1'b0; low++; end
      drv_a(32'h8C000000, 1'b0, mr);
      #3;
      if (a.state == 4'd5) rd++;
      if (a.write_dr) pulses++;
      if (a.state == 4'd9 && a.memtoreg && a.write_reg) m2r++;
      tick();
    end
    #3;
    chk("lw_memrd_cycles", rd, 4);
    chk("lw_write_dr_pulses", pulses, 1);
    chk("lw_wbld_memtoreg", m2r, 1);
    chk("lw_end_state", 32'(a.state), 0);
    chk("lw_retired", 32'(a.retired), 1);

    // Reset in the middle of a stalled store, after five retired jumps
    do_reset();
    for (int j = 0; j < 15; j++) begin drv_a(32'h08000000, 1'b0, 1'b1); tick(); end
    drv_a(32'hAC000000, 1'b0, 1'b1);
    #3;
    chk("sw_pre_retired", 32'(a.retired), 5);
    tick(); tick(); tick();
    drv_a(32'hAC000000, 1'b0, 1'b0);
    #3;
    chk("sw_wait_state", 32'(a.state), 6);
    chk("sw_wait_write_mem", 32'(a.write_mem), 1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    #3;
    chk("swrst_state", 32'(a.state), 0);
    chk("swrst_retired", 32'(a.retired), 0);
    chk("swrst_write_mem", 32'(a.write_mem), 0);
    chk("swrst_ctl", 32'(ctl_a), 32'(exp_ctl(0, 32'hAC000000, 1'b0, 1'b0)));

    // Fetch timeout with TMO_W=2: trap after three stalled cycles
    do_reset();
    drv_b('0, 1'b0, 1'b0);
    n = 0;
    for (int j = 0; j < 10 && b.state != 4'd15; j++) begin n++; tick(); end
    #3;
    chk("tmo_wait_cycles", n, 3);
    chk("tmo_state", 32'(b.state), 15);
    chk("tmo_bus_err", 32'(b.bus_err), 1);
    chk("tmo_illegal", 32'(b.illegal), 0);
    chk("tmo_write_pc", 32'(b.write_pc), 1);
    chk("tmo_pcsource", 32'(b.pcsource), 3);
    tick();
    #3;
    chk("tmo_back_if", 32'(b.state), 0);
    chk("tmo_retired", 32'(b.retired), 0);

    // Ready arriving on the limit cycle completes the fetch normally
    do_reset();
    drv_b('0, 1'b0, 1'b0);
    tick(); tick();
    drv_b('0, 1'b0, 1'b1);
    #3;
    chk("tmo_edge_write_ir", 32'(b.write_ir), 1);
    tick();
    #3;
    chk("tmo_edge_state", 32'(b.state), 1);
    chk("tmo_edge_bus_err", 32'(b.bus_err), 0);

    // EN_IMM=0: ADDI is illegal
    do_reset();
    drv_b(32'h20000000, 1'b0, 1'b1);
    tick(); tick();
    #3;
    chk("noimm_state", 32'(b.state), 15);
    chk("noimm_illegal", 32'(b.illegal), 1);
    tick();
    #3;
    chk("noimm_retired", 32'(b.retired), 0);

    // Randomized program against the instruction-level model
    do_reset();
    cur = 0; wait_n = 0; ret_m = 0; ill_m = 1'b0; bus_m = 1'b0; stall = 1'b0;
    q.delete();
    ir = gen_insn();
    for (int c = 0; c < 2000; c++) begin
      if (c % 60 == 0) stall = ($urandom_range(0, 3) == 0);
      mr = stall ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 99) < 70);
      z  = 1'($urandom_range(0, 1));
      drv_a(ir, z, mr);
      #3;
      chk_ctl_a($sformatf("rnd%0d", c), cur, ir, z, mr);
      chk($sformatf("rnd%0d_retired", c), 32'(a.retired), ret_m & 32'hFFFF);
      chk($sformatf("rnd%0d_illegal", c), 32'(a.illegal), 32'(ill_m));
      chk($sformatf("rnd%0d_bus_err", c), 32'(a.bus_err), 32'(bus_m));
      if ((cur == 0 || cur == 5 || cur == 6) && !mr) begin
        wait_n++;
        if (wait_n == TMO_LIM_A) begin cur = 15; q.delete(); bus_m = 1'b1; wait_n = 0; end
      end else begin
        wait_n = 0;
        if (cur == 0) q = path_of(ir);
        if (q.size() > 0) begin
          cur = q.pop_front();
          if (cur == 15) ill_m = 1'b1;
        end else begin
          if (cur != 15) ret_m++;
          cur = 0;
          ir = gen_insn();
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
